// File: rtl/frame_scanner.sv
// frame_scanner: row-major raster walk driving the renderer coordinate,
// registering its colour into a valid/ready pixel stream with frame markers.
module frame_scanner #(
  parameter int SCREEN_WIDTH  = 400,
  parameter int SCREEN_HEIGHT = 700,
  parameter int COORD_W       = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  output logic [COORD_W-1:0] scan_x,
  output logic [COORD_W-1:0] scan_y,
  input  logic [23:0]        color_in,
  output logic               pix_valid,
  input  logic               pix_ready,
  output logic [23:0]        pix_color,
  output logic [COORD_W-1:0] pix_x,
  output logic [COORD_W-1:0] pix_y,
  output logic               pix_sof,
  output logic               pix_eol,
  output logic               pix_eof,
  output logic               busy,
  output logic               frame_done,
  output logic [15:0]        frame_count
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SCAN  = 2'd1;
  localparam logic [1:0] DRAIN = 2'd2;

  localparam logic [COORD_W-1:0] XMAX = COORD_W'(SCREEN_WIDTH - 1);
  localparam logic [COORD_W-1:0] YMAX = COORD_W'(SCREEN_HEIGHT - 1);
  localparam logic [COORD_W-1:0] ONE  = COORD_W'(1);

  logic [1:0] state;
  logic       advance;
  logic       x_last;
  logic       y_last;

  assign advance = !pix_valid || pix_ready;
  assign x_last  = (scan_x == XMAX);
  assign y_last  = (scan_y == YMAX);
  assign busy    = (state == SCAN) || (state == DRAIN);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      scan_x      <= '0;
      scan_y      <= '0;
      pix_valid   <= 1'b0;
      pix_color   <= '0;
      pix_x       <= '0;
      pix_y       <= '0;
      pix_sof     <= 1'b0;
      pix_eol     <= 1'b0;
      pix_eof     <= 1'b0;
      frame_done  <= 1'b0;
      frame_count <= '0;
    end else begin
      frame_done <= 1'b0;
      case (state)
        IDLE: begin
          if (pix_ready) pix_valid <= 1'b0;
          if (start) begin
            state  <= SCAN;
            scan_x <= '0;
            scan_y <= '0;
          end
        end
        SCAN: begin
          if (advance) begin
            pix_valid <= 1'b1;
            pix_color <= color_in;
            pix_x     <= scan_x;
            pix_y     <= scan_y;
            pix_sof   <= (scan_x == '0) && (scan_y == '0);
            pix_eol   <= x_last;
            pix_eof   <= x_last && y_last;
            // last pixel loaded: park the coordinate at origin for next frame
            if (x_last && y_last) begin
              scan_x <= '0;
              scan_y <= '0;
              state  <= DRAIN;
            end else if (x_last) begin
              scan_x <= '0;
              scan_y <= scan_y + ONE;
            end else begin
              scan_x <= scan_x + ONE;
            end
          end
        end
        DRAIN: begin
          if (pix_ready) begin
            pix_valid   <= 1'b0;
            frame_done  <= 1'b1;
            frame_count <= frame_count + 16'd1;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_frame_scanner.sv
// tb_frame_scanner: scoreboard bench for a 4x3 frame_scanner.
// Stimulus queues expected pixels; a negedge monitor pops and compares.
module tb_frame_scanner;

  localparam int W  = 4;
  localparam int H  = 3;
  localparam int CW = 32;

  typedef struct packed {
    logic [23:0] c;
    logic [31:0] x;
    logic [31:0] y;
    logic        sof;
    logic        eol;
    logic        eof;
  } pix_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [CW-1:0] scan_x, scan_y;
  logic [23:0]   color_in;
  logic          pix_valid, pix_ready;
  logic [23:0]   pix_color;
  logic [CW-1:0] pix_x, pix_y;
  logic          pix_sof, pix_eol, pix_eof;
  logic          busy, frame_done;
  logic [15:0]   frame_count;

  logic ready_q = 1'b1;
  logic rnd_en = 1'b0;
  logic rnd_bit = 1'b0;

  int total = 0;
  int bad = 0;

  pix_t        q[$];
  logic [15:0] exp_count = '0;
  logic        done_pend = 1'b0;
  logic        prev_stall = 1'b0;
  pix_t        saved;

  assign pix_ready = rnd_en ? rnd_bit : ready_q;
  assign color_in  = {8'h00, scan_x[7:0], scan_y[7:0]};

  frame_scanner #(
    .SCREEN_WIDTH (W),
    .SCREEN_HEIGHT(H),
    .COORD_W      (CW)
  ) dut (
    .clk        (clk),
    .reset      (rst),
    .start      (start),
    .scan_x     (scan_x),
    .scan_y     (scan_y),
    .color_in   (color_in),
    .pix_valid  (pix_valid),
    .pix_ready  (pix_ready),
    .pix_color  (pix_color),
    .pix_x      (pix_x),
    .pix_y      (pix_y),
    .pix_sof    (pix_sof),
    .pix_eol    (pix_eol),
    .pix_eof    (pix_eof),
    .busy       (busy),
    .frame_done (frame_done),
    .frame_count(frame_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [95:0] act,
                     input logic [95:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  function automatic pix_t cur_pix();
    pix_t p;
    p.c   = pix_color;
    p.x   = pix_x;
    p.y   = pix_y;
    p.sof = pix_sof;
    p.eol = pix_eol;
    p.eof = pix_eof;
    return p;
  endfunction

  // reference model: one whole frame in row-major order
  task automatic push_frame();
    pix_t p;
    for (int y = 0; y < H; y++) begin
      for (int x = 0; x < W; x++) begin
        p.x   = 32'(x);
        p.y   = 32'(y);
        p.c   = {8'h00, p.x[7:0], p.y[7:0]};
        p.sof = (x == 0) && (y == 0);
        p.eol = (x == W - 1);
        p.eof = (x == W - 1) && (y == H - 1);
        q.push_back(p);
      end
    end
  endtask

  task automatic issue_start();
    push_frame();
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic wait_pix(input int x, input int y);
    bit found = 0;
    for (int i = 0; i < 300 && !found; i++) begin
      if (pix_valid && pix_x == 32'(x) && pix_y == 32'(y)) found = 1;
      else begin
        @(posedge clk);
        #1;
      end
    end
    chk("wait_pix_timeout", 96'(found), 96'd1);
  endtask

  task automatic wait_done();
    bit found = 0;
    for (int i = 0; i < 400 && !found; i++) begin
      @(posedge clk);
      #1;
      if (frame_done) found = 1;
    end
    chk("wait_done_timeout", 96'(found), 96'd1);
  endtask

  initial begin
    forever begin
      @(posedge clk);
      #1;
      rnd_bit = 1'($urandom_range(0, 1));
    end
  end

  // monitor: every accept pops the scoreboard; stalls must hold payload
  initial begin
    pix_t p;
    pix_t e;
    forever begin
      @(negedge clk);
      if (rst) begin
        q.delete();
        done_pend  = 1'b0;
        prev_stall = 1'b0;
      end else begin
        p = cur_pix();
        if (prev_stall) begin
          chk("stall_valid", 96'(pix_valid), 96'd1);
          chk("stall_payload", 96'(p), 96'(saved));
        end
        chk("frame_done", 96'(frame_done), 96'(done_pend));
        if (done_pend) begin
          chk("frame_count", 96'(frame_count), 96'(exp_count));
          chk("busy_after_frame", 96'(busy), 96'd0);
        end
        done_pend = 1'b0;
        if (pix_valid && pix_ready) begin
          if (q.size() == 0) begin
            chk("extra_pix", 96'd1, 96'd0);
          end else begin
            e = q.pop_front();
            chk("pixel", 96'(p), 96'(e));
            if (e.eof) begin
              exp_count = exp_count + 16'd1;
              done_pend = 1'b1;
            end
          end
        end
        prev_stall = pix_valid && !pix_ready;
        saved      = p;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    logic [15:0] fc0;
    #23;
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("reset_out", 96'({pix_valid, pix_color, pix_x, pix_y,
                          pix_sof, pix_eol, pix_eof}), 96'd0);
    chk("reset_stat", 96'({busy, frame_done, frame_count}), 96'd0);

    // abort mid-frame with async reset
    ready_q = 1'b1;
    issue_start();
    wait_pix(1, 1);
    #1;
    rst = 1'b1;
    #1;
    chk("abort_out", 96'({pix_valid, pix_color, pix_x, pix_y,
                          pix_sof, pix_eol, pix_eof}), 96'd0);
    chk("abort_scan", 96'({scan_x, scan_y}), 96'd0);
    chk("abort_stat", 96'({busy, frame_done, frame_count}), 96'd0);
    #5;
    rst = 1'b0;
    exp_count = '0;
    @(posedge clk);
    #1;

    // full frame at 1 pixel/clk, latency from start to frame_done
    push_frame();
    start = 1'b1;
    n = 0;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk);
      n++;
      #1;
      if (n == 1) start = 1'b0;
      if (frame_done) break;
    end
    chk("done_latency", 96'(n), 96'd14);
    chk("fc_first", 96'(frame_count), 96'd1);
    repeat (2) @(posedge clk);
    #1;
    chk("idle_valid_low", 96'({pix_valid, busy}), 96'd0);

    // 5-cycle stall at (2,1)
    issue_start();
    wait_pix(2, 1);
    ready_q = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    chk("stall_hold_x", 96'({pix_valid, pix_x, pix_y}),
        96'({1'b1, 32'd2, 32'd1}));
    ready_q = 1'b1;
    wait_done();

    // start while busy is dropped
    fc0 = frame_count;
    issue_start();
    wait_pix(1, 1);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_done();
    repeat (30) @(posedge clk);
    #1;
    chk("restart_ignored", 96'(frame_count), 96'(fc0 + 16'd1));
    chk("restart_idle", 96'({busy, pix_valid}), 96'd0);

    // three back-to-back frames under random backpressure
    rst = 1'b1;
    #2;
    @(negedge clk);
    #1;
    rst = 1'b0;
    exp_count = '0;
    @(posedge clk);
    #1;
    rnd_en = 1'b1;
    for (int f = 0; f < 3; f++) begin
      issue_start();
      wait_done();
    end
    rnd_en = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("fc_random", 96'(frame_count), 96'd3);
    chk("queue_empty", 96'(q.size()), 96'd0);
    chk("final_idle", 96'(busy), 96'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
